// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA display back end.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } vga_state_e;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_PIXW      = 12;
  localparam int DEF_PPW       = 2;

endpackage

// File: rtl/vga_timing.sv
// Free-running VGA h/v counters with combinational active, sync and frame-start decode.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [HW-1:0] h_cnt,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          vblank,
  output logic          frame_start
);

  logic [VW-1:0] v_cnt;
  logic [31:0]   hx;
  logic [31:0]   vx;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HW'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Compare at 32 bits so a zero back porch cannot overflow the window bounds.
  assign hx          = 32'(h_cnt);
  assign vx          = 32'(v_cnt);
  assign active      = (hx < 32'(H_DISPLAY)) && (vx < 32'(V_DISPLAY));
  assign hsync       = !((hx >= 32'(H_DISPLAY + H_FRONT)) &&
                         (hx <  32'(H_DISPLAY + H_FRONT + H_SYNC)));
  assign vsync       = !((vx >= 32'(V_DISPLAY + V_FRONT)) &&
                         (vx <  32'(V_DISPLAY + V_FRONT + V_SYNC)));
  assign vblank      = (vx >= 32'(V_DISPLAY));
  assign frame_start = (hx == 32'd0) && (vx == 32'd0);

endmodule

// File: rtl/vga_video_out.sv
// VGA back end: pops packed pixel words from the async FIFO read side, unpacks
// them into registered RGB/sync pins and recovers from underflow at frame start.
module vga_video_out
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int PIXW      = DEF_PIXW,
  parameter int PPW       = DEF_PPW,
  localparam int WORDW    = PPW * PIXW,
  localparam int HW       = $clog2(H_DISPLAY + H_FRONT + H_SYNC + H_BACK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WORDW-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_read,
  output logic [PIXW-1:0]  vga_rgb,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic             video_on,
  output logic             vblank,
  output logic             underflow,
  input  logic             underflow_clr,
  output vga_state_e       state
);

  localparam int IDXW = (PPW > 1) ? $clog2(PPW) : 1;

  logic [HW-1:0]   h_cnt;
  logic            active;
  logic            hsync_t;
  logic            vsync_t;
  logic            vblank_t;
  logic            frame_start;
  logic [IDXW-1:0] lane;
  logic            need;

  vga_state_e      next_state;
  logic            start_run;
  logic            run_now;
  logic            disp_read;
  logic            underflow_evt;

  logic [IDXW-1:0] idx_s1;
  logic            active_s1;
  logic            hsync_s1;
  logic            vsync_s1;
  logic            vblank_s1;
  logic            word_valid_s1;

  vga_timing #(
    .H_DISPLAY (H_DISPLAY), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
    .V_DISPLAY (V_DISPLAY), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .h_cnt       (h_cnt),
    .active      (active),
    .hsync       (hsync_t),
    .vsync       (vsync_t),
    .vblank      (vblank_t),
    .frame_start (frame_start)
  );

  assign lane = IDXW'(32'(h_cnt) % PPW);
  assign need = active && (lane == '0);

  // FIFO handshake: fifo_read is a pop request raised only while fifo_empty is
  // low; the popped word sits on fifo_dout from the next cycle until the next pop.
  // A frame start with data present promotes IDLE/FLUSH to RUN in the same cycle,
  // so the word for pixel (0,0) is fetched on time.
  always_comb begin
    next_state    = state;
    start_run     = frame_start && !fifo_empty && (state != ST_RUN);
    run_now       = (state == ST_RUN) || start_run;
    disp_read     = run_now && need && !fifo_empty && !rst;
    underflow_evt = (state == ST_RUN) && need && fifo_empty;
    fifo_read     = disp_read || ((state == ST_FLUSH) && !fifo_empty && !rst);
    unique case (state)
      ST_IDLE:  if (start_run)     next_state = ST_RUN;
      ST_RUN:   if (underflow_evt) next_state = ST_FLUSH;
      ST_FLUSH: if (frame_start)   next_state = fifo_empty ? ST_IDLE : ST_RUN;
      default:                     next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      underflow     <= 1'b0;
      idx_s1        <= '0;
      active_s1     <= 1'b0;
      hsync_s1      <= 1'b1;
      vsync_s1      <= 1'b1;
      vblank_s1     <= 1'b0;
      word_valid_s1 <= 1'b0;
      vga_rgb       <= '0;
      vga_hsync     <= 1'b1;
      vga_vsync     <= 1'b1;
      video_on      <= 1'b0;
      vblank        <= 1'b0;
    end else begin
      state <= next_state;
      if (underflow_evt)      underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;

      // Validity is decided once per word and held for its remaining lanes.
      if (need) word_valid_s1 <= disp_read;
      idx_s1    <= lane;
      active_s1 <= active;
      hsync_s1  <= hsync_t;
      vsync_s1  <= vsync_t;
      vblank_s1 <= vblank_t;

      vga_rgb   <= (word_valid_s1 && active_s1) ? fifo_dout[idx_s1*PIXW +: PIXW] : '0;
      vga_hsync <= hsync_s1;
      vga_vsync <= vsync_s1;
      video_on  <= active_s1;
      vblank    <= vblank_s1;
    end
  end

endmodule

// File: tb/tb_vga_video_out.sv
// Directed scoreboard bench for vga_video_out on a shrunken 8x4 raster, plus a
// PPW=1/PIXW=24 instance sharing the same timing.
module tb_vga_video_out;
  import vga_pkg::*;

  localparam int HD = 8, HF = 2, HS = 3, HB = 2;
  localparam int VD = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic vb;
  } tim_t;
  localparam tim_t RST_T = '{hs: 1'b1, vs: 1'b1, act: 1'b0, vb: 1'b0};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT (PPW=2, PIXW=12)
  logic [23:0] fifo_dout = '0;
  logic        fifo_empty;
  logic        fifo_read;
  logic [11:0] vga_rgb;
  logic        vga_hsync, vga_vsync, video_on, vblank, underflow;
  logic        underflow_clr = 1'b0;
  vga_state_e  state;

  // second DUT (PPW=1, PIXW=24), FIFO never empty
  logic [23:0] fifo_dout1 = '0;
  logic        fifo_read1;
  logic [23:0] vga_rgb1;
  logic        vga_hsync1, vga_vsync1, video_on1, vblank1, underflow1;
  vga_state_e  state1;

  vga_video_out #(
    .H_DISPLAY (HD), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_DISPLAY (VD), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .PIXW (12), .PPW (2)
  ) u_dut (
    .clk (clk), .rst (rst), .fifo_dout (fifo_dout), .fifo_empty (fifo_empty),
    .fifo_read (fifo_read), .vga_rgb (vga_rgb), .vga_hsync (vga_hsync),
    .vga_vsync (vga_vsync), .video_on (video_on), .vblank (vblank),
    .underflow (underflow), .underflow_clr (underflow_clr), .state (state)
  );

  vga_video_out #(
    .H_DISPLAY (HD), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_DISPLAY (VD), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .PIXW (24), .PPW (1)
  ) u_dut1 (
    .clk (clk), .rst (rst), .fifo_dout (fifo_dout1), .fifo_empty (1'b0),
    .fifo_read (fifo_read1), .vga_rgb (vga_rgb1), .vga_hsync (vga_hsync1),
    .vga_vsync (vga_vsync1), .video_on (video_on1), .vblank (vblank1),
    .underflow (underflow1), .underflow_clr (1'b0), .state (state1)
  );

  // scoreboard state
  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp_q[$];
  int          pop_count = 0;
  int          avail_limit = 0;
  int          reads1 = 0;
  int          disp1 = 0;
  int          hs_low = 0;
  int          vs_low = 0;
  bit          no_read_phase = 1'b1;
  bit          dut1_chk = 1'b1;

  // reference raster
  int   h_m = 0;
  int   v_m = 0;
  tim_t hist1 = RST_T;
  tim_t hist2 = RST_T;

  assign fifo_empty = (pop_count >= avail_limit);

  function automatic logic [11:0] pix(input int k, input int l);
    return 12'((2 * k + l) * 5 + 'h123);
  endfunction

  function automatic tim_t decode(input int h, input int v);
    tim_t t;
    t.hs  = !((h >= HD + HF) && (h < HD + HF + HS));
    t.vs  = !((v >= VD + VF) && (v < VD + VF + VS));
    t.act = (h < HD) && (v < VD);
    t.vb  = (v >= VD);
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue the pins' expected rgb for the next `total` active pixels; the first
  // `nv` come from consecutive FIFO words starting at `base`, the rest are blank.
  task automatic push_frame(input int base, input int nv, input int total);
    for (int i = 0; i < total; i++)
      exp_q.push_back((i < nv) ? pix(base + i / 2, i % 2) : 12'h000);
  endtask

  task automatic wait_pos(input int h, input int v);
    for (int i = 0; i < 2 * HT * VT + 10; i++) begin
      @(negedge clk);
      if (h_m == h && v_m == v) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_pos: raster (%0d,%0d) never reached", h, v);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rgb"},       32'(vga_rgb),   32'h0);
    check({tag, "_hsync"},     32'(vga_hsync), 32'h1);
    check({tag, "_vsync"},     32'(vga_vsync), 32'h1);
    check({tag, "_video_on"},  32'(video_on),  32'h0);
    check({tag, "_vblank"},    32'(vblank),    32'h0);
    check({tag, "_underflow"}, 32'(underflow), 32'h0);
    check({tag, "_fifo_read"}, 32'(fifo_read), 32'h0);
    check({tag, "_state"},     32'(state),     32'(ST_IDLE));
  endtask

  // FIFO models: pop on the clock edge, data visible the following cycle
  initial begin
    forever begin
      @(posedge clk);
      if (fifo_read) begin
        fifo_dout <= {pix(pop_count, 1), pix(pop_count, 0)};
        pop_count <= pop_count + 1;
      end
      if (fifo_read1) begin
        fifo_dout1 <= 24'(reads1 * 3 + 1);
        reads1     <= reads1 + 1;
      end
    end
  end

  // raster reference with the two-stage pin latency
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        h_m = 0;
        v_m = 0;
        hist1 = RST_T;
        hist2 = RST_T;
      end else begin
        hist2 = hist1;
        hist1 = decode(h_m, v_m);
        if (h_m == HT - 1) begin
          h_m = 0;
          v_m = (v_m == VT - 1) ? 0 : v_m + 1;
        end else begin
          h_m++;
        end
      end
    end
  end

  // monitor: timing pins every cycle, rgb popped from the scoreboard on video_on
  initial begin
    forever begin
      @(negedge clk);
      check("hsync",    32'(vga_hsync),  32'(hist2.hs));
      check("vsync",    32'(vga_vsync),  32'(hist2.vs));
      check("video_on", 32'(video_on),   32'(hist2.act));
      check("vblank",   32'(vblank),     32'(hist2.vb));
      check("hsync1",   32'(vga_hsync1), 32'(hist2.hs));
      check("vsync1",   32'(vga_vsync1), 32'(hist2.vs));
      check("read_when_empty", 32'(fifo_read && fifo_empty), 32'h0);
      if (no_read_phase) check("idle_read", 32'(fifo_read), 32'h0);
      if (!rst && !vga_hsync) hs_low++;
      if (!rst && !vga_vsync) vs_low++;
      if (video_on) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rgb_unexpected: got %0h with no pixel queued", vga_rgb);
        end else begin
          check("rgb", 32'(vga_rgb), 32'(exp_q.pop_front()));
        end
      end else begin
        check("rgb_blank", 32'(vga_rgb), 32'h0);
      end
      if (dut1_chk && video_on1) begin
        check("rgb1", 32'(vga_rgb1), 32'(24'(disp1 * 3 + 1)));
        disp1++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // stimulus
  int base;
  initial begin
    push_frame(0, 0, 2 * HD * VD);
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // frames 0 and 1: FIFO empty, DUT must idle without reading
    wait_pos(0, VD);
    wait_pos(0, 0);
    wait_pos(0, VD);
    check("idle_state", 32'(state), 32'(ST_IDLE));
    check("hsync_low_cycles", 32'(hs_low), 32'(12 * HS));
    check("vsync_low_cycles", 32'(vs_low), 32'(VS * HT));
    check("ppw1_reads_2frames", 32'(reads1), 32'(2 * HD * VD));
    no_read_phase = 1'b0;

    // frame 2: clean frame
    base = pop_count;
    avail_limit = base + HD * VD / 2;
    push_frame(base, HD * VD, HD * VD);
    wait_pos(0, 0);
    wait_pos(0, VD);
    check("clean_reads", 32'(pop_count - base), 32'(HD * VD / 2));
    check("clean_state", 32'(state), 32'(ST_RUN));
    check("clean_underflow", 32'(underflow), 32'h0);

    // frame 3: data runs out after line 2 word 0
    base = pop_count;
    avail_limit = base + 9;
    push_frame(base, 18, HD * VD);
    wait_pos(0, 0);
    wait_pos(0, 3);
    check("uf_flag", 32'(underflow), 32'h1);
    check("uf_state", 32'(state), 32'(ST_FLUSH));
    avail_limit = pop_count + 5;
    repeat (8) @(negedge clk);
    check("flush_drained", 32'(pop_count), 32'(avail_limit));

    // vblank: clear the sticky flag
    wait_pos(0, VD);
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;
    check("uf_clear", 32'(underflow), 32'h0);

    // frame 4: data arrives exactly at frame start, FLUSH resynchronises to RUN
    base = pop_count;
    push_frame(base, HD * VD, HD * VD);
    wait_pos(0, 0);
    avail_limit = base + HD * VD / 2;
    push_frame(0, 0, HD * VD);
    wait_pos(0, VD);
    check("resync_reads", 32'(pop_count - base), 32'(HD * VD / 2));
    check("resync_state", 32'(state), 32'(ST_RUN));

    // frame 5: underflow on the very first word with clear asserted alongside
    wait_pos(0, 0);
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;
    check("uf_set_priority", 32'(underflow), 32'h1);
    check("uf_first_state", 32'(state), 32'(ST_FLUSH));

    // frame 6: reset in the middle of line 1 while running
    base = pop_count;
    push_frame(base, 10, 10);
    wait_pos(0, 0);
    avail_limit = base + HD * VD / 2;
    wait_pos(3, 1);
    check("pre_reset_state", 32'(state), 32'(ST_RUN));
    rst = 1'b1;
    dut1_chk = 1'b0;
    avail_limit = pop_count;
    push_frame(0, 0, HD * VD);
    @(negedge clk);
    check_reset_values("midreset");
    rst = 1'b0;

    // frame 7: idle after reset with raster restarted from (0,0)
    wait_pos(0, VD);
    check("final_state", 32'(state), 32'(ST_IDLE));
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    check("ppw1_pixels_seen", 32'(disp1 >= 5 * HD * VD), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
